// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong geometry, colours and seven-segment table
package pong_pkg;

  // Object geometry shared with the game-logic block
  localparam int PADDLE_H = 100;
  localparam int PADDLE_W = 12;
  localparam int BALL_S   = 10;
  localparam int P1_X     = 40;
  localparam int P2_X_OFF = 52;

  // Colours as {R,G,B}
  localparam logic [23:0] COL_BALL   = 24'hFFFF00;
  localparam logic [23:0] COL_PADDLE = 24'hFFFFFF;
  localparam logic [23:0] COL_DIGIT  = 24'h00FF00;
  localparam logic [23:0] COL_NET    = 24'h808080;
  localparam logic [23:0] COL_BG     = 24'h000000;

  // Segments per digit as {a,b,c,d,e,f,g}; entries 10..15 are blank
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Game state captured once per frame
  typedef struct packed {
    logic [10:0] p1_y;
    logic [10:0] p2_y;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
  } snap_t;

endpackage

// File: rtl/pong_digit_hit.sv
// rtl/pong_digit_hit.sv - seven-segment score digit hit test for one pixel
module pong_digit_hit
  import pong_pkg::*;
#(
  parameter int DIGIT_W = 40,
  parameter int DIGIT_H = 70,
  parameter int SEG_T   = 8
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [10:0] ox,
  input  logic [10:0] oy,
  input  logic [3:0]  digit,
  output logic        hit
);

  // Middle bar sits centred on the vertical midpoint of the box
  localparam int MID  = DIGIT_H / 2;
  localparam int G_LO = MID - SEG_T / 2;
  localparam int G_HI = MID + SEG_T / 2;

  logic [11:0] xe, ye, oxe, oye, u, v;
  logic        in_box;
  logic [6:0]  segs;
  logic        sa, sb, sc, sd, se, sf, sg;

  // Box test at 12 bits, then local-coordinate segment regions gated by the digit map
  always_comb begin
    xe     = {1'b0, x};
    ye     = {1'b0, y};
    oxe    = {1'b0, ox};
    oye    = {1'b0, oy};
    in_box = (xe >= oxe) && (xe < oxe + 12'(DIGIT_W)) &&
             (ye >= oye) && (ye < oye + 12'(DIGIT_H));
    u      = xe - oxe;
    v      = ye - oye;
    segs   = SEG_LUT[digit];
    sa     = v < 12'(SEG_T);
    sg     = (v >= 12'(G_LO)) && (v < 12'(G_HI));
    sd     = v >= 12'(DIGIT_H - SEG_T);
    sf     = (u < 12'(SEG_T)) && (v < 12'(MID));
    sb     = (u >= 12'(DIGIT_W - SEG_T)) && (v < 12'(MID));
    se     = (u < 12'(SEG_T)) && (v >= 12'(MID));
    sc     = (u >= 12'(DIGIT_W - SEG_T)) && (v >= 12'(MID));
    hit    = in_box && ((segs[6] && sa) || (segs[5] && sb) || (segs[4] && sc) ||
                        (segs[3] && sd) || (segs[2] && se) || (segs[1] && sf) ||
                        (segs[0] && sg));
  end

endmodule

// File: rtl/pong_render.sv
// rtl/pong_render.sv - two-stage pong pixel renderer with per-frame state snapshot
module pong_render
  import pong_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int NET_W    = 4,
  parameter int DIGIT_W  = 40,
  parameter int DIGIT_H  = 70,
  parameter int SEG_T    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [3:0]  score_l,
  input  logic [3:0]  score_r,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic [23:0] rgb
);

  localparam logic [10:0] DL_X  = 11'(H_ACTIVE / 2 - 80);
  localparam logic [10:0] DR_X  = 11'(H_ACTIVE / 2 + 40);
  localparam logic [10:0] DIG_Y = 11'd20;

  logic        fs_d1, fs_d2;
  snap_t       snap;
  logic        snap_valid;

  logic [11:0] xe, ye, bx, by, p1e, p2e;
  logic        in_screen;
  logic        c_ball, c_p1, c_p2, c_net;
  logic        dl_hit, dr_hit;

  logic        hit_ball, hit_p1, hit_p2, hit_digit_l, hit_digit_r, hit_net;
  logic        de1, hs1, vs1;
  logic [23:0] pix;
  logic [23:0] rgb_q;
  logic        de2, hs2, vs2;

  // Delay frame_start so the snapshot catches the game-logic update it triggered
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_d1      <= 1'b0;
      fs_d2      <= 1'b0;
      snap       <= '0;
      snap_valid <= 1'b0;
    end else begin
      fs_d1 <= frame_start;
      fs_d2 <= fs_d1;
      if (fs_d2) begin
        snap.p1_y    <= p1_y;
        snap.p2_y    <= p2_y;
        snap.ball_x  <= ball_x;
        snap.ball_y  <= ball_y;
        snap.score_l <= score_l;
        snap.score_r <= score_r;
        snap_valid   <= 1'b1;
      end
    end
  end

  pong_digit_hit #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H), .SEG_T(SEG_T)) u_digit_l (
    .x(x), .y(y), .ox(DL_X), .oy(DIG_Y), .digit(snap.score_l), .hit(dl_hit)
  );

  pong_digit_hit #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H), .SEG_T(SEG_T)) u_digit_r (
    .x(x), .y(y), .ox(DR_X), .oy(DIG_Y), .digit(snap.score_r), .hit(dr_hit)
  );

  // Object region tests at 12 bits so right/bottom edges never wrap
  always_comb begin
    xe        = {1'b0, x};
    ye        = {1'b0, y};
    bx        = {1'b0, snap.ball_x};
    by        = {1'b0, snap.ball_y};
    p1e       = {1'b0, snap.p1_y};
    p2e       = {1'b0, snap.p2_y};
    in_screen = (xe < 12'(H_ACTIVE)) && (ye < 12'(V_ACTIVE));
    c_ball    = (xe >= bx) && (xe < bx + 12'(BALL_S)) &&
                (ye >= by) && (ye < by + 12'(BALL_S));
    c_p1      = (xe >= 12'(P1_X)) && (xe < 12'(P1_X + PADDLE_W)) &&
                (ye >= p1e) && (ye < p1e + 12'(PADDLE_H));
    c_p2      = (xe >= 12'(H_ACTIVE - P2_X_OFF)) &&
                (xe < 12'(H_ACTIVE - P2_X_OFF + PADDLE_W)) &&
                (ye >= p2e) && (ye < p2e + 12'(PADDLE_H));
    c_net     = (xe >= 12'(H_ACTIVE / 2 - NET_W / 2)) &&
                (xe < 12'(H_ACTIVE / 2 + NET_W / 2)) && !y[4];
  end

  // Stage 1: register hit flags (objects only once a snapshot exists) and syncs
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_ball    <= 1'b0;
      hit_p1      <= 1'b0;
      hit_p2      <= 1'b0;
      hit_digit_l <= 1'b0;
      hit_digit_r <= 1'b0;
      hit_net     <= 1'b0;
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
    end else begin
      hit_ball    <= in_screen && snap_valid && c_ball;
      hit_p1      <= in_screen && snap_valid && c_p1;
      hit_p2      <= in_screen && snap_valid && c_p2;
      hit_digit_l <= in_screen && snap_valid && dl_hit;
      hit_digit_r <= in_screen && snap_valid && dr_hit;
      hit_net     <= in_screen && c_net;
      de1         <= de_in;
      hs1         <= hs_in;
      vs1         <= vs_in;
    end
  end

  // Priority mux: ball over paddles over digits over net, black outside active video
  always_comb begin
    pix = COL_BG;
    if (!de1)                            pix = COL_BG;
    else if (hit_ball)                   pix = COL_BALL;
    else if (hit_p1 || hit_p2)           pix = COL_PADDLE;
    else if (hit_digit_l || hit_digit_r) pix = COL_DIGIT;
    else if (hit_net)                    pix = COL_NET;
  end

  // Stage 2: register colour and syncs for the encoder
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      de2   <= 1'b0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
    end else begin
      rgb_q <= pix;
      de2   <= de1;
      hs2   <= hs1;
      vs2   <= vs1;
    end
  end

  // Outputs are held low for as long as reset is asserted, not just after the next edge
  assign rgb    = reset ? 24'h0 : rgb_q;
  assign de_out = reset ? 1'b0 : de2;
  assign hs_out = reset ? 1'b0 : hs2;
  assign vs_out = reset ? 1'b0 : vs2;

endmodule

// File: tb/tb_pong_render.sv
// tb/tb_pong_render.sv - scoreboard bench for pong_render
module tb_pong_render;

  localparam logic [23:0] YEL = 24'hFFFF00;
  localparam logic [23:0] WHT = 24'hFFFFFF;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] GRY = 24'h808080;
  localparam logic [23:0] BLK = 24'h000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        de_in = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
  logic [10:0] x = '0, y = '0;
  logic [10:0] p1_y = '0, p2_y = '0, ball_x = '0, ball_y = '0;
  logic [3:0]  score_l = '0, score_r = '0;
  logic        de_out, hs_out, vs_out;
  logic [23:0] rgb;

  pong_render dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .x(x), .y(y),
    .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score_l(score_l), .score_r(score_r),
    .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [26:0] exp;
    bit          chk_rgb;
    int          id;
  } item_t;

  item_t       q[$];
  int          next_id = 0;
  int          total = 0;
  int          bad = 0;
  bit          done = 1'b0;
  int unsigned rnd;

  task automatic push(input int due, input logic [26:0] e, input bit c);
    item_t it;
    it.due = due; it.exp = e; it.chk_rgb = c; it.id = next_id;
    next_id++;
    q.push_back(it);
  endtask

  // One pixel clock of stimulus; expectation appears two cycles later
  task automatic step(input logic f, input logic d, input logic h, input logic v,
                      input logic [10:0] px, input logic [10:0] py,
                      input logic [23:0] er, input bit c, input bit do_push);
    @(posedge clk); #1;
    reset = 1'b0; frame_start = f; de_in = d; hs_in = h; vs_in = v; x = px; y = py;
    if (do_push) push(cyc + 2, {d, h, v, er}, c);
  endtask

  // Reset cycle with active inputs; optionally checks outputs within the same cycle
  task automatic rst_step(input bit first);
    @(posedge clk); #1;
    reset = 1'b1; frame_start = 1'b0; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    if (first) push(cyc, 27'h0, 1'b1);
    push(cyc + 2, 27'h0, 1'b1);
  endtask

  task automatic px_chk(input logic [10:0] px, input logic [10:0] py, input logic [23:0] er);
    step(1'b0, 1'b1, 1'b0, 1'b1, px, py, er, 1'b1, 1'b1);
  endtask

  // New game state, frame_start with de_in=1, then two pixels still on the old snapshot
  task automatic load(input logic [10:0] a_p1, input logic [10:0] a_p2,
                      input logic [10:0] a_bx, input logic [10:0] a_by,
                      input logic [3:0] a_sl, input logic [3:0] a_sr,
                      input logic [10:0] px, input logic [10:0] py, input logic [23:0] old_rgb);
    p1_y = a_p1; p2_y = a_p2; ball_x = a_bx; ball_y = a_by; score_l = a_sl; score_r = a_sr;
    step(1'b1, 1'b1, 1'b0, 1'b0, px, py, old_rgb, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, px, py, old_rgb, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, px, py, old_rgb, 1'b1, 1'b1);
  endtask

  initial begin
    p1_y = 11'd310; p2_y = 11'd100; ball_x = 11'd600; ball_y = 11'd300;
    score_l = 4'd8; score_r = 4'd0;
    rst_step(1'b1); rst_step(1'b0); rst_step(1'b0);

    // No snapshot yet: net and background only
    px_chk(11'd640, 11'd8,   GRY);
    px_chk(11'd640, 11'd16,  BLK);
    px_chk(11'd45,  11'd310, BLK);
    px_chk(11'd605, 11'd305, BLK);

    load(11'd310, 11'd100, 11'd600, 11'd300, 4'd8, 4'd0, 11'd605, 11'd305, BLK);
    px_chk(11'd605, 11'd305, YEL);
    ball_x = 11'd700;
    px_chk(11'd605, 11'd305, YEL);
    px_chk(11'd705, 11'd305, BLK);
    px_chk(11'd580, 11'd23,  GRN);
    px_chk(11'd596, 11'd40,  GRN);
    px_chk(11'd596, 11'd75,  GRN);
    px_chk(11'd580, 11'd86,  GRN);
    px_chk(11'd564, 11'd75,  GRN);
    px_chk(11'd564, 11'd40,  GRN);
    px_chk(11'd580, 11'd55,  GRN);
    px_chk(11'd700, 11'd23,  GRN);
    px_chk(11'd700, 11'd55,  BLK);
    px_chk(11'd1230, 11'd150, WHT);
    px_chk(11'd640, 11'd8,   GRY);

    load(11'd310, 11'd100, 11'd40, 11'd310, 4'd1, 4'd0, 11'd605, 11'd305, YEL);
    px_chk(11'd605, 11'd305, BLK);
    px_chk(11'd45,  11'd315, YEL);
    px_chk(11'd45,  11'd330, WHT);
    px_chk(11'd596, 11'd50,  GRN);
    px_chk(11'd596, 11'd75,  GRN);
    px_chk(11'd565, 11'd24,  BLK);
    px_chk(11'd564, 11'd75,  BLK);

    load(11'd310, 11'd100, 11'd1275, 11'd500, 4'd12, 4'd0, 11'd45, 11'd315, YEL);
    px_chk(11'd1279, 11'd505, YEL);
    px_chk(11'd0,    11'd505, BLK);
    px_chk(11'd45,   11'd315, WHT);
    px_chk(11'd580, 11'd23,  BLK);
    px_chk(11'd564, 11'd40,  BLK);
    px_chk(11'd596, 11'd75,  BLK);
    px_chk(11'd580, 11'd55,  BLK);

    // Random sync/DE patterns over an empty pixel
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      step(1'b0, rnd[0], rnd[1], rnd[2], 11'd300, 11'd600, BLK, 1'b1, 1'b1);
    end

    // Reset in the middle of active video over the ball
    step(1'b0, 1'b1, 1'b1, 1'b1, 11'd1279, 11'd505, YEL, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 11'd1279, 11'd505, YEL, 1'b1, 1'b0);
    rst_step(1'b1); rst_step(1'b0); rst_step(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 11'd1279, 11'd505, BLK, 1'b1, 1'b1);
    px_chk(11'd640, 11'd8,   GRY);
    px_chk(11'd45,  11'd330, BLK);
    load(11'd310, 11'd100, 11'd1275, 11'd500, 4'd12, 4'd0, 11'd1279, 11'd505, BLK);
    px_chk(11'd1279, 11'd505, YEL);

    step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, BLK, 1'b1, 1'b1);
    repeat (6) @(posedge clk);
    done = 1'b1;
  end

  // Monitor: compare every output sample that has an expectation due this cycle
  initial begin
    item_t       it;
    logic [26:0] act;
    logic [26:0] msk;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        it  = q.pop_front();
        act = {de_out, hs_out, vs_out, rgb};
        msk = it.chk_rgb ? 27'h7FFFFFF : 27'h7000000;
        total++;
        if (it.due != cyc || ((act & msk) !== (it.exp & msk))) begin
          bad++;
          $display("FAIL item%0d cyc%0d: got de,hs,vs=%b%b%b rgb=%06h, want de,hs,vs=%b%b%b rgb=%06h",
                   it.id, cyc, act[26], act[25], act[24], act[23:0],
                   it.exp[26], it.exp[25], it.exp[24], it.exp[23:0]);
        end
      end
      if (done) begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL drain: got %0d pending items, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/pong_render.md
Name: pong_render

Overview:
- Pixel renderer that sits directly downstream of the pong game-logic block.
- Consumes paddle, ball and score state plus raster coordinates and sync signals from video_timing.
- Produces registered 24-bit RGB with sync/DE delayed to match, for the HDMI encoder.
- Holds a once-per-frame snapshot of game state so that no object tears mid-frame.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- NET_W, 4, centre-net width in px
- DIGIT_W, 40, score digit width in px
- DIGIT_H, 70, score digit height in px
- SEG_T, 8, seven-segment stroke thickness in px

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per frame during blanking; same pulse that drives the game-logic block
- de_in  in  1  active-video enable
- hs_in  in  1  hsync
- vs_in  in  1  vsync
- x  in  11  current pixel column; valid when de_in=1
- y  in  11  current pixel row; valid when de_in=1
- p1_y  in  11  left paddle top
- p2_y  in  11  right paddle top
- ball_x  in  11  ball left
- ball_y  in  11  ball top
- score_l  in  4  left score
- score_r  in  4  right score
- de_out  out  1  de_in delayed 2 cycles
- hs_out  out  1  hs_in delayed 2 cycles
- vs_out  out  1  vs_in delayed 2 cycles
- rgb  out  24  {R[7:0],G[7:0],B[7:0]}

Behaviour:
- Reset: rgb=0, de_out/hs_out/vs_out=0, all pipeline registers cleared, snapshot registers = 0, snap_valid=0.
- Snapshot load:
  - The game-logic outputs change on the edge that samples frame_start.
  - frame_start is delayed 2 cycles to form load_pulse.
  - On load_pulse, p1_y, p2_y, ball_x, ball_y, score_l and score_r are copied into the snapshot and snap_valid is set to 1.
  - The snapshot is unchanged at all other times.
- Pipeline, fixed latency of 2 clk:
  - Stage 1 registers hit flags computed from x, y and the snapshot: hit_ball, hit_p1, hit_p2, hit_digit_l, hit_digit_r, hit_net. It also registers the stage-1 de/hs/vs.
  - Stage 2 registers rgb from a priority mux and registers the stage-2 de/hs/vs.
- Hit regions (half-open intervals, compared at 12 bits to avoid overflow):
  - ball: ball_x ≤ x < ball_x+10 and ball_y ≤ y < ball_y+10
  - p1: 40 ≤ x < 52 and p1_y ≤ y < p1_y+100
  - p2: H_ACTIVE-52 ≤ x < H_ACTIVE-40 and p2_y ≤ y < p2_y+100
  - net: H_ACTIVE/2-NET_W/2 ≤ x < H_ACTIVE/2+NET_W/2 and y[4]=0 (16-px dashes)
  - left digit origin (H_ACTIVE/2-80, 20); right digit origin (H_ACTIVE/2+40, 20); box DIGIT_W×DIGIT_H
- Segment geometry, with local u=x-ox and v=y-oy:
  - a: v<SEG_T
  - g: 31≤v<39
  - d: v≥DIGIT_H-SEG_T
  - f: u<SEG_T and v<35
  - b: u≥DIGIT_W-SEG_T and v<35
  - e: u<SEG_T and v≥35
  - c: u≥DIGIT_W-SEG_T and v≥35
  - Standard 0–9 segment map; scores 10–15 draw nothing (blank).
- Priority and colours:
  - ball 0xFFFF00 > paddle 0xFFFFFF > digit 0x00FF00 > net 0x808080 > background 0x000000.
- If snap_valid=0: only net and background are drawn.
- rgb is forced to 0 whenever stage-2 de=0.
- Sync signals are passed through unmodified, with delay only.
- Edge cases:
  - frame_start coincident with de_in=1: snapshot still loads; this is a legal upstream error and must not corrupt the pipeline.
  - Objects at the screen edge (ball_x+10 > H_ACTIVE): only the in-range pixels are drawn, with no wrap.
  - Reset mid-frame: outputs are 0 while reset is high. Sync resumes 2 cycles after release. Objects reappear only after the next load_pulse.
- Two consecutive frame_start pulses: each produces its own load; the last one wins.

Decomposition:
- Package pong_pkg holds:
  - PADDLE_H=100, PADDLE_W=12, BALL_S=10, P1_X=40, P2_X_OFF=52
  - colour constants
  - seven-segment lookup constant (digit→7-bit abcdefg)
- One sub-module, pong_digit_hit: combinational; inputs x, y, origin, 4-bit digit; output hit. Instantiated twice.
- The game-logic block also imports pong_pkg so that both sides share the same geometry.

Test Plan:
- Latency: toggle de_in/hs_in/vs_in with random patterns → de_out/hs_out/vs_out equal the inputs delayed exactly 2 clk; rgb=0 whenever de_out=0.
- Snapshot: ball_x=600, ball_y=300, pulse frame_start, then change ball_x to 700 mid-frame → pixel (605,305) is 0xFFFF00 and (705,305) is not, until the next load.
- Before first load, after reset: pixel (640,8) is 0x808080, (640,16) is 0x000000, and (45,310) is black.
- Priority: ball_x=40, ball_y=310, p1_y=310 → pixel (45,315) is 0xFFFF00; pixel (45,330) is 0xFFFFFF.
- Digits:
  - score_l=8 → all seven left-digit segment centres are green.
  - score_l=1 → only b and c are green, e.g. (596,50) green and (565,24) black.
  - score_l=12 → entire left digit box is black.
- Reset mid-frame during de_in=1 → rgb and syncs are 0 in the same cycle; after release, objects stay black until load_pulse.
